// File: rtl/core_array_drain.sv
// core_array_drain: shifts ROWS words out of a PE chain and streams them as 16-bit signed lanes.
// Latency: first word on o_res_valid SHIFT_LAT+2 cycles after the first o_cell_out_en_pre.
// Backpressure: FIFO absorbs i_res_ready stalls; a burst starts only when ROWS slots are free. DRAIN_SAT_EN saturates mode-0 lanes.
module core_array_drain #(
    parameter int ROWS         = 8,
    parameter int PE_OUT_WIDTH = 64,
    parameter int LANE88_W     = 24,
    parameter int LANE18_W     = 16,
    parameter int SHIFT_LAT    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_mode,
    input  logic                    i_drain_start,
    output logic                    o_drain_busy,
    output logic                    o_drain_done,
    output logic                    o_cell_out_en_pre,
    input  logic [PE_OUT_WIDTH-1:0] i_arr_out,
    output logic [4*LANE18_W-1:0]   o_res_lanes,
    output logic [2:0]              o_res_lane_cnt,
    output logic                    o_res_last,
    output logic                    o_res_valid,
    input  logic                    i_res_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int RW = $clog2(ROWS);
    localparam int EW = PE_OUT_WIDTH + 2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT, S_FLUSH} state_t;

    state_t                r_state;
    logic                  r_mode_q;
    logic                  r_en_pre;
    logic [RW-1:0]         r_shift_cnt;
    logic [RW-1:0]         r_cap_cnt;
    logic [SHIFT_LAT-1:0]  r_dly;
    logic [EW-1:0]         r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_mem_cnt;
    logic                  r_out_vld;
    logic [EW-1:0]         r_out_dat;
    logic                  r_done;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_cap_last;
    logic [CW-1:0]         w_occ;
    logic                  w_room;
    logic [PE_OUT_WIDTH-1:0] w_word;
    logic [4*LANE18_W-1:0] w_lanes;
    logic [2:0]            w_cnt;
    logic                  w_last;

    assign w_push     = r_dly[SHIFT_LAT-1];
    assign w_pop      = r_out_vld & i_res_ready;
    assign w_load     = (r_mem_cnt != '0) & (~r_out_vld | w_pop);
    assign w_cap_last = (r_cap_cnt == RW'(ROWS - 1));
    // Occupancy counts the output register too, so reserved space covers every stored word.
    assign w_occ      = r_mem_cnt + CW'(r_out_vld);
    assign w_room     = (CW'(FIFO_DEPTH) - w_occ) >= CW'(ROWS);
    assign w_word     = r_out_dat[PE_OUT_WIDTH-1:0];

    // The FSM never waits on downstream pops; completion is signalled when the tagged last word leaves.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_mode_q    <= 1'b0;
            r_en_pre    <= 1'b0;
            r_shift_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_drain_start) begin
                        r_mode_q <= i_mode;
                        if (w_room) begin
                            r_state  <= S_SHIFT;
                            r_en_pre <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_room) begin
                        r_state  <= S_SHIFT;
                        r_en_pre <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (r_shift_cnt == RW'(ROWS - 1)) begin
                        r_state     <= S_FLUSH;
                        r_en_pre    <= 1'b0;
                        r_shift_cnt <= '0;
                    end else begin
                        r_shift_cnt <= r_shift_cnt + RW'(1);
                    end
                end
                S_FLUSH: begin
                    if (w_push && w_cap_last) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_dly     <= '0;
            r_cap_cnt <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_mem_cnt <= '0;
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
            r_done    <= 1'b0;
        end else begin
            r_dly[0] <= r_en_pre;
            for (int i = 1; i < SHIFT_LAT; i++) r_dly[i] <= r_dly[i-1];
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + PW'(1);
                r_cap_cnt <= w_cap_last ? '0 : r_cap_cnt + RW'(1);
            end
            if (w_load) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_mem_cnt <= r_mem_cnt + CW'(w_push) - CW'(w_load);
            if (w_load) begin
                r_out_dat <= r_mem[r_rd_ptr];
                r_out_vld <= 1'b1;
            end else if (w_pop) begin
                r_out_vld <= 1'b0;
            end
            r_done <= w_pop & r_out_dat[PE_OUT_WIDTH];
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {r_mode_q, w_cap_last, i_arr_out};
    end

    assert property (@(posedge i_clk) disable iff (!i_reset_n)
        !(w_push && (w_occ == CW'(FIFO_DEPTH)) && !w_pop));

`ifdef DRAIN_SAT_EN
    function automatic logic [LANE18_W-1:0] sat_lane(input logic [LANE88_W-1:0] v);
        if ((v[LANE88_W-1:LANE18_W-1] == '0) || (&v[LANE88_W-1:LANE18_W-1]))
            return v[LANE18_W-1:0];
        else if (v[LANE88_W-1])
            return {1'b1, {(LANE18_W-1){1'b0}}};
        else
            return {1'b0, {(LANE18_W-1){1'b1}}};
    endfunction
`endif

    always_comb begin
        w_lanes = '0;
        w_cnt   = 3'd0;
        w_last  = 1'b0;
        if (r_out_vld) begin
            w_last = r_out_dat[PE_OUT_WIDTH];
            if (r_out_dat[EW-1]) begin
                w_lanes = w_word[4*LANE18_W-1:0];
                w_cnt   = 3'd4;
            end else begin
`ifdef DRAIN_SAT_EN
                w_lanes[LANE18_W-1:0]          = sat_lane(w_word[LANE88_W-1:0]);
                w_lanes[2*LANE18_W-1:LANE18_W] = sat_lane(w_word[2*LANE88_W-1:LANE88_W]);
`else
                w_lanes[LANE18_W-1:0]          = w_word[LANE18_W-1:0];
                w_lanes[2*LANE18_W-1:LANE18_W] = w_word[LANE88_W +: LANE18_W];
`endif
                w_cnt = 3'd2;
            end
        end
    end

    assign o_res_lanes       = w_lanes;
    assign o_res_lane_cnt    = w_cnt;
    assign o_res_last        = w_last;
    assign o_res_valid       = r_out_vld;
    assign o_cell_out_en_pre = r_en_pre;
    assign o_drain_done      = r_done;
    assign o_drain_busy      = (r_state != S_IDLE) | (w_occ != '0);
endmodule

// File: tb/tb_core_array_drain.sv
// Directed bench for core_array_drain: a small PE-chain model feeds arr_out, expectations are hand-computed.
module tb_core_array_drain;
    logic        clk = 1'b0;
    logic        reset_n, mode, drain_start, res_ready;
    logic        drain_busy, drain_done, cell_out_en_pre, res_last, res_valid;
    logic [63:0] arr_out, res_lanes;
    logic [2:0]  res_lane_cnt;

    int vec = 0, miss = 0;
    int en_total = 0, base = 0, pat = 0;
    logic [15:0] off = 16'h0;
    logic [63:0] exp_w [8];
    logic [2:0]  exp_cnt;
    int got, ens, dones, first_vld;
    logic prev_lp;

    always #5 clk = ~clk;

    // Chain model: word i appears one cycle after the i-th enable.
    always @(posedge clk) if (cell_out_en_pre) en_total <= en_total + 1;

    function automatic logic [63:0] gen_word(input int p, input logic [15:0] o, input int i);
        case (p)
            1:       return {16'h0, 24'hFFFFFE, 24'h001234};
            2:       return {16'h0, 24'hFE0000, 24'h012345};
            default: return {4{o + 16'(i)}};
        endcase
    endfunction
    assign arr_out = gen_word(pat, off, en_total - base - 1);

    core_array_drain dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_mode(mode), .i_drain_start(drain_start),
        .o_drain_busy(drain_busy), .o_drain_done(drain_done), .o_cell_out_en_pre(cell_out_en_pre),
        .i_arr_out(arr_out), .o_res_lanes(res_lanes), .o_res_lane_cnt(res_lane_cnt),
        .o_res_last(res_last), .o_res_valid(res_valid), .i_res_ready(res_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic m, input int p, input logic [15:0] o);
        mode = m; pat = p; off = o; base = en_total;
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
    endtask

    task automatic fill_ramp(input logic [15:0] o);
        for (int i = 0; i < 8; i++) exp_w[i] = {4{o + 16'(i)}};
        exp_cnt = 3'd4;
    endtask

    // Called in the first enable cycle; res_ready must be 1.
    task automatic run_burst(input string pfx, input int budget, input int poke_at, input int exp_first);
        got = 0; ens = 0; dones = 0; first_vld = -1; prev_lp = 1'b0;
        for (int c = 0; c < budget; c++) begin
            drain_start = (c == poke_at);
            if (cell_out_en_pre) ens++;
            if (prev_lp || drain_done) chk({pfx, "_done_timing"}, 64'(drain_done), 64'(prev_lp));
            if (drain_done) dones++;
            prev_lp = res_valid & res_ready & res_last;
            if (res_valid && res_ready) begin
                if (first_vld < 0) first_vld = c;
                if (got < 8) begin
                    chk({pfx, "_lanes"}, res_lanes, exp_w[got]);
                    chk({pfx, "_lane_cnt"}, 64'(res_lane_cnt), 64'(exp_cnt));
                    chk({pfx, "_last"}, 64'(res_last), 64'(got == 7));
                end
                got++;
            end
            step();
        end
        drain_start = 1'b0;
        chk({pfx, "_words"}, 64'(got), 64'd8);
        chk({pfx, "_enables"}, 64'(ens), 64'd8);
        chk({pfx, "_done_pulses"}, 64'(dones), 64'd1);
        chk({pfx, "_first_latency"}, 64'(first_vld), 64'(exp_first));
        chk({pfx, "_idle_busy"}, 64'(drain_busy), 64'd0);
    endtask

    function automatic logic [15:0] t4_val(input int k);
        return 16'((k / 8 + 1) * 256 + k % 8);
    endfunction

    initial begin
        reset_n = 1'b0; mode = 1'b0; drain_start = 1'b0; res_ready = 1'b0;
        #2;
        chk("rst_busy", 64'(drain_busy), 64'd0);
        chk("rst_done", 64'(drain_done), 64'd0);
        chk("rst_en_pre", 64'(cell_out_en_pre), 64'd0);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_lanes", res_lanes, 64'd0);
        chk("rst_lane_cnt", 64'(res_lane_cnt), 64'd0);
        chk("rst_last", 64'(res_last), 64'd0);
        step(); step();
        reset_n = 1'b1;
        step();

        // Mode 1 ramp.
        res_ready = 1'b1;
        fill_ramp(16'h0000);
        start_burst(1'b1, 0, 16'h0000);
        chk("t1_en_pre_start", 64'(cell_out_en_pre), 64'd1);
        chk("t1_busy_start", 64'(drain_busy), 64'd1);
        run_burst("t1", 16, -1, 3);

        // Mode 0 in-range lanes, with a start pulse during SHIFT that must be ignored.
        for (int i = 0; i < 8; i++) exp_w[i] = {16'h0, 16'h0, 16'hFFFE, 16'h1234};
        exp_cnt = 3'd2;
        start_burst(1'b0, 1, 16'h0000);
        run_burst("t2", 16, 2, 3);

        // Mode 0 out-of-range lanes.
`ifdef DRAIN_SAT_EN
        for (int i = 0; i < 8; i++) exp_w[i] = {16'h0, 16'h0, 16'h8000, 16'h7FFF};
`else
        for (int i = 0; i < 8; i++) exp_w[i] = {16'h0, 16'h0, 16'h0000, 16'h2345};
`endif
        start_burst(1'b0, 2, 16'h0000);
        run_burst("t3", 16, -1, 3);

        // Backpressure: two bursts fill the FIFO, a third waits for room.
        res_ready = 1'b0;
        start_burst(1'b1, 0, 16'h0100);
        for (int c = 0; c < 12; c++) step();
        chk("t4_hold_valid", 64'(res_valid), 64'd1);
        chk("t4_hold_lanes", res_lanes, {4{16'h0100}});
        start_burst(1'b1, 0, 16'h0200);
        chk("t4_b2_immediate", 64'(cell_out_en_pre), 64'd1);
        for (int c = 0; c < 12; c++) step();
        chk("t4_b2_hold_lanes", res_lanes, {4{16'h0100}});
        chk("t4_b2_hold_last", 64'(res_last), 64'd0);
        start_burst(1'b1, 0, 16'h0300);
        ens = 0;
        for (int c = 0; c < 5; c++) begin
            if (cell_out_en_pre) ens++;
            step();
        end
        chk("t4_wait_no_shift", 64'(ens), 64'd0);
        chk("t4_wait_busy", 64'(drain_busy), 64'd1);
        res_ready = 1'b1;
        got = 0; ens = 0; dones = 0;
        for (int c = 0; c < 60; c++) begin
            if (cell_out_en_pre) begin
                if (ens == 0) chk("t4_wait_release_pops", 64'(got), 64'd9);
                ens++;
            end
            if (drain_done) dones++;
            if (res_valid) begin
                if (got < 24) begin
                    chk("t4_order_lanes", res_lanes, {4{t4_val(got)}});
                    chk("t4_order_last", 64'(res_last), 64'(got % 8 == 7));
                end
                got++;
            end
            step();
        end
        chk("t4_words", 64'(got), 64'd24);
        chk("t4_b3_enables", 64'(ens), 64'd8);
        chk("t4_done_pulses", 64'(dones), 64'd3);
        chk("t4_idle_busy", 64'(drain_busy), 64'd0);

        // Reset in the fourth SHIFT cycle, then a clean burst.
        start_burst(1'b1, 0, 16'h0040);
        step(); step(); step();
        reset_n = 1'b0;
        #1;
        chk("t6_rst_en_pre", 64'(cell_out_en_pre), 64'd0);
        chk("t6_rst_valid", 64'(res_valid), 64'd0);
        chk("t6_rst_busy", 64'(drain_busy), 64'd0);
        chk("t6_rst_lanes", res_lanes, 64'd0);
        chk("t6_rst_lane_cnt", 64'(res_lane_cnt), 64'd0);
        chk("t6_rst_last", 64'(res_last), 64'd0);
        chk("t6_rst_done", 64'(drain_done), 64'd0);
        step();
        reset_n = 1'b1;
        step();
        chk("t6_post_rst_valid", 64'(res_valid), 64'd0);
        fill_ramp(16'h0040);
        start_burst(1'b1, 0, 16'h0040);
        run_burst("t6", 16, -1, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
